// File: rtl/nibble_deserializer.sv
// Serial-to-nibble deserializer with a one-entry output register, an overrun flag
// and a mod-3 remainder tracker over the bit stream received since the last reset/sync.
module nibble_deserializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       sync,
  output logic [3:0] a,
  output logic       a_valid,
  input  logic       a_ready,
  output logic       stream_by3,
  output logic       overrun,
  output logic [7:0] nibble_count
);

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2
  } rem_e;

  rem_e       rem_q, rem_d, rem_base;
  logic [1:0] cnt_q;
  logic [3:0] shreg_q, shreg_base, shreg_nxt;
  logic       complete, xfer;

  // A sync cycle restarts from an empty shift register, so a bit arriving with sync
  // is shifted into zeros as the first bit of the new frame.
  always_comb begin
    shreg_base = sync ? 4'b0000 : shreg_q;
    if (MSB_FIRST) shreg_nxt = {shreg_base[2:0], bit_in};
    else           shreg_nxt = {bit_in, shreg_base[3:1]};
  end

  assign complete = bit_valid && !sync && (cnt_q == 2'd3);
  assign xfer     = a_valid && a_ready;

  // Remainder next-state: r' = (2r + bit) mod 3, always read MSB-first.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rem_base = sync ? R0 : rem_q;
    rem_d    = rem_base;
    if (bit_valid) begin
      case (rem_base)
        R0:      rem_d = bit_in ? R1 : R0;
        R1:      rem_d = bit_in ? R0 : R2;
        R2:      rem_d = bit_in ? R2 : R1;
        default: rem_d = R0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem_q <= R0;
    else        rem_q <= rem_d;
  end

  assign stream_by3 = (rem_q == R0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shreg_q <= 4'b0000;
    end else if (sync) begin
      cnt_q   <= bit_valid ? 2'd1 : 2'd0;
      shreg_q <= bit_valid ? shreg_nxt : 4'b0000;
    end else if (bit_valid) begin
      cnt_q   <= cnt_q + 2'd1;
      shreg_q <= shreg_nxt;
    end
  end

  // Output register: a new nibble is taken only if the slot is empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a            <= 4'b0000;
      a_valid      <= 1'b0;
      overrun      <= 1'b0;
      nibble_count <= 8'd0;
    end else begin
      if (complete && (!a_valid || a_ready)) begin
        a       <= shreg_nxt;
        a_valid <= 1'b1;
      end else if (xfer) begin
        a_valid <= 1'b0;
      end

      if (sync)                             overrun <= 1'b0;
      else if (complete && a_valid && !a_ready) overrun <= 1'b1;

      if (xfer) nibble_count <= nibble_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_nibble_deserializer.sv
// Randomized scoreboard bench for nibble_deserializer; both bit orders run side by side
// from the same stimulus and are checked against a frame-level reference model.
module tb_nibble_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0, bit_valid = 1'b0, sync = 1'b0, a_ready = 1'b0;
  logic [3:0] a1, a0;
  logic       av1, av0, by31, by30, ovr1, ovr0;
  logic [7:0] cnt1, cnt0;

  always #5 clk = ~clk;

  nibble_deserializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
    .a(a1), .a_valid(av1), .a_ready(a_ready), .stream_by3(by31), .overrun(ovr1),
    .nibble_count(cnt1));

  nibble_deserializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
    .a(a0), .a_valid(av0), .a_ready(a_ready), .stream_by3(by30), .overrun(ovr0),
    .nibble_count(cnt0));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: observable state after the most recent edge.
  typedef struct { logic [3:0] m1; logic [3:0] m0; } nib_t;
  nib_t exp_q[$];
  bit   frame_q[$];
  bit   cur_occ = 0, cur_ovr = 0;
  int   cur_cnt = 0, cur_rem = 0;

  task automatic step(input bit v, input bit b, input bit s, input bit r);
    bit   xfer, complete;
    bit   nxt_occ, nxt_ovr;
    int   nxt_cnt, nxt_rem;
    nib_t n;
    bit_valid = v; bit_in = b; sync = s; a_ready = r;
    xfer     = cur_occ && r;
    complete = 0;
    nxt_occ  = cur_occ;
    nxt_ovr  = cur_ovr;
    nxt_cnt  = xfer ? (cur_cnt + 1) % 256 : cur_cnt;
    nxt_rem  = cur_rem;
    n.m1 = 0; n.m0 = 0;
    if (s) begin
      frame_q.delete();
      nxt_rem = 0;
      nxt_ovr = 0;
    end
    if (v) begin
      frame_q.push_back(b);
      nxt_rem = (2 * nxt_rem + int'(b)) % 3;
      if (frame_q.size() == 4) begin
        complete = 1;
        for (int i = 0; i < 4; i++) begin
          n.m1 = n.m1 + (4'(frame_q[i]) << (3 - i));
          n.m0 = n.m0 + (4'(frame_q[i]) << i);
        end
        frame_q.delete();
      end
    end
    if (complete) begin
      if (!cur_occ || xfer) begin
        exp_q.push_back(n);
        nxt_occ = 1;
      end else begin
        nxt_ovr = 1;
      end
    end else if (xfer) begin
      nxt_occ = 0;
    end
    @(posedge clk);
    #1;
    cur_occ = nxt_occ; cur_ovr = nxt_ovr; cur_cnt = nxt_cnt; cur_rem = nxt_rem;
  endtask

  task automatic send(input logic [3:0] nib, input bit r);
    for (int i = 3; i >= 0; i--) step(1, nib[i], 0, r);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic do_reset();
    bit_valid = 0; sync = 0; a_ready = 0; bit_in = 0;
    rst_n = 0;
    #2;
    check("rst_a1", a1, 4'h0);
    check("rst_a0", a0, 4'h0);
    check("rst_av", av1, 1'b0);
    check("rst_by3", by31, 1'b1);
    check("rst_ovr", ovr1, 1'b0);
    check("rst_cnt", cnt1, 8'd0);
    frame_q.delete();
    exp_q.delete();
    cur_occ = 0; cur_ovr = 0; cur_cnt = 0; cur_rem = 0;
    rst_n = 1;
  endtask

  // Monitor: compares every output each cycle and pops the scoreboard on each transfer.
  always @(negedge clk) begin
    nib_t e;
    check("a_valid1", av1, cur_occ);
    check("a_valid0", av0, cur_occ);
    check("overrun1", ovr1, cur_ovr);
    check("overrun0", ovr0, cur_ovr);
    check("count1", cnt1, cur_cnt[7:0]);
    check("count0", cnt0, cur_cnt[7:0]);
    check("by3_1", by31, cur_rem == 0);
    check("by3_0", by30, cur_rem == 0);
    if (av1 && a_ready && rst_n) begin
      if (exp_q.size() == 0) begin
        check("xfer_without_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("xfer_a1", a1, e.m1);
        check("xfer_a0", a0, e.m0);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    check("init_a", a1, 4'h0);
    check("init_by3", by31, 1'b1);

    // Bits 0,1,1,0 with downstream ready: value 6.
    send(4'b0110, 1);
    check("s32_a1", a1, 4'b0110);
    check("s32_av", av1, 1'b1);
    check("s32_by3", by31, 1'b1);
    step(0, 0, 0, 1);
    check("s32_av_cleared", av1, 1'b0);
    check("s32_cnt", cnt1, 8'd1);
    check("s32_a_hold", a1, 4'b0110);

    // Bits 1,0,1,1: LSB-first order gives 1101; stream 0110_1011 mod 3 = 2.
    send(4'b1011, 1);
    check("s33_a0", a0, 4'b1101);
    check("s33_by3", by31, 1'b0);
    step(0, 0, 0, 1);

    // Held output: second nibble is dropped and overrun latches.
    send(4'b0011, 0);
    send(4'b1001, 0);
    check("s34_a_held", a1, 4'b0011);
    check("s34_ovr", ovr1, 1'b1);
    check("s34_cnt", cnt1, 8'd2);
    step(0, 0, 0, 1);
    check("s34_cnt_after", cnt1, 8'd3);
    check("s34_av", av1, 1'b0);

    // Completion coinciding with a transfer keeps a_valid high.
    step(0, 0, 1, 0);
    check("sync_clears_ovr", ovr1, 1'b0);
    send(4'b0101, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    check("s35_a1", a1, 4'b1100);
    check("s35_av", av1, 1'b1);
    check("s35_cnt", cnt1, 8'd4);
    step(0, 0, 0, 1);

    // Sync with a valid bit starts a fresh frame: 1,0,0,1 -> 9.
    step(1, 1, 0, 1); step(1, 0, 0, 1);
    step(1, 1, 1, 1);
    step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
    check("s36_a1", a1, 4'b1001);
    check("s36_by3", by31, 1'b1);
    check("s36_ovr", ovr1, 1'b0);
    step(0, 0, 0, 1);

    // Reset mid-nibble, then a fresh nibble.
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    do_reset();
    send(4'b1010, 1);
    check("post_rst_a1", a1, 4'b1010);
    step(0, 0, 0, 1);

    // Randomized traffic with occasional sync.
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0);
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    // 256 transfers wrap the counter back to zero.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 256; i++) send(4'($urandom), 1);
    step(0, 0, 0, 1);
    check("wrap_cnt", cnt1, 8'd0);
    check("wrap_av", av1, 1'b0);

    step(0, 0, 0, 1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_deserializer.md
NIBBLE_DESERIALIZER -- requirements
Module: nibble_deserializer

Interface
REQ-001 SHALL have parameter: MSB_FIRST, default 1, 1 = first received bit lands in a[3] and 0 = first received bit lands in a[0].
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: bit_in  input  1  serial data bit.
REQ-005 SHALL have port: bit_valid  input  1  bit_in is sampled this cycle.
REQ-006 SHALL have port: sync  input  1  frame realign, restarts nibble assembly and the remainder FSM.
REQ-007 SHALL have port: a  output  4  assembled nibble, registered, feeds the downstream divisibility checker.
REQ-008 SHALL have port: a_valid  output  1  a holds an untransferred nibble.
REQ-009 SHALL have port: a_ready  input  1  downstream accepts a this cycle.
REQ-010 SHALL have port: stream_by3  output  1  serial value received since last reset/sync is divisible by 3.
REQ-011 SHALL have port: overrun  output  1  sticky flag, a completed nibble was dropped.
REQ-012 SHALL have port: nibble_count  output  8  number of completed transfers.

Function
REQ-013 SHALL keep a 2-bit bit counter (0..3) and a 4-bit shift register, both advancing only on cycles with bit_valid=1.
REQ-014 SHALL shift as follows: MSB_FIRST=1: shreg <= {shreg[2:0],bit_in}; MSB_FIRST=0: shreg <= {bit_in,shreg[3:1]}.
REQ-015 SHALL complete a nibble on a bit_valid cycle with counter=3, where the assembled value is the shift result including the current bit; the counter then wraps to 0.
REQ-016 SHALL define a transfer as a rising edge with a_valid=1 and a_ready=1, and SHALL increment nibble_count on each transfer, wrapping 255->0.
REQ-017 SHALL, on completion with a_valid=0, load a with the new nibble and set a_valid=1 at the next edge, giving latency of 1 clock from the 4th bit sample to a_valid.
REQ-018 SHALL, on completion with a_valid=1 and a_ready=1 in the same cycle, transfer the old nibble, load the new one, and keep a_valid=1.
REQ-019 SHALL, on completion with a_valid=1 and a_ready=0, leave a unchanged, drop the new nibble, and set overrun=1.
REQ-020 SHALL, on a transfer with no completion in the same cycle, clear a_valid; a SHALL retain its last value.
REQ-021 SHALL hold a stable while a_valid=1 and a_ready=0.
REQ-022 SHALL maintain a remainder FSM with states R0, R1, R2 that interprets the stream MSB-first regardless of MSB_FIRST, with next = (2*r + bit_in) mod 3 on each bit_valid cycle.
REQ-023 SHALL use these remainder FSM transitions: R0 -0-> R0, R0 -1-> R1, R1 -0-> R2, R1 -1-> R0, R2 -0-> R1, R2 -1-> R2.
REQ-024 SHALL drive stream_by3 = 1 exactly when the FSM state is R0, as a combinational decode of the state register.
REQ-025 SHALL, when sync=1, clear the counter, shreg, and FSM (R0) and clear overrun; a, a_valid, and nibble_count SHALL be unaffected, and transfers SHALL still occur.
REQ-026 SHALL, when sync=1 and bit_valid=1 in the same cycle, take the bit as the first bit of the new frame (counter -> 1, FSM -> next state from R0, shreg = shift of 0 with bit_in).
REQ-027 SHALL never complete a nibble on a sync cycle.
REQ-028 SHALL ignore bit_in when bit_valid=0, with no state change except transfers.

Reset
REQ-029 SHALL, on rst_n=0, immediately set, without waiting for clk: counter=0, shreg=4'b0000, FSM=R0, a=4'b0000, a_valid=0, overrun=0, nibble_count=8'd0; stream_by3 therefore reads 1.
REQ-030 SHALL discard any partial nibble and any pending a_valid when reset is asserted mid-frame.
REQ-031 SHALL, after reset release, accept the first bit_valid on the first rising edge.

Verification
REQ-032 SHALL cover this scenario: MSB_FIRST=1, a_ready=1, bits 0,1,1,0 on consecutive cycles -> a=4'b0110, a_valid=1 for 1 cycle, nibble_count=1, stream_by3=1 (value 6).
REQ-033 SHALL cover this scenario: MSB_FIRST=0, bits 1,0,1,1 -> a=4'b1101; stream_by3 after bits 1,0,1,1 (MSB-first 11) = 0, FSM=R2.
REQ-034 SHALL cover this scenario: a_ready=0, two nibbles 4'b0011 then 4'b1001 -> a stays 4'b0011, overrun=1 after 8th bit, nibble_count=0; then a_ready=1 for 1 cycle -> count=1, a_valid=0.
REQ-035 SHALL cover this scenario: 4th bit completes while a_ready=1 and a_valid=1 -> old transferred, new loaded, a_valid remains 1, count +1.
REQ-036 SHALL cover this scenario: 2 bits sent, then sync with bit_valid=1, bit_in=1, then 3 more bits 0,0,1 -> a=4'b1001 (MSB_FIRST=1), stream_by3=1, overrun=0.
REQ-037 SHALL cover this scenario: rst_n pulsed low mid-nibble between clock edges -> all outputs at reset values immediately, next 4 bits form a fresh nibble; 256 transfers -> nibble_count wraps to 0.
